// File: rtl/mux_pipe_stage_if.sv
// Handshake bundle for mux_pipe_stage: upstream select/offer side and downstream
// result side. The stage itself takes the slave modport.
interface mux_pipe_stage_if #(
  parameter int WIDTH  = 64,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = 2,
  parameter int CNT_W  = 16
);
  logic [NUM_IN*WIDTH-1:0] in_data;
  logic [SEL_W-1:0]        in_sel;
  logic                    in_valid;
  logic                    in_ready;
  logic                    flush;
  logic [WIDTH-1:0]        out_data;
  logic                    out_sel_err;
  logic                    out_valid;
  logic                    out_ready;
  logic [CNT_W-1:0]        xfer_cnt;

  modport slave (
    input  in_data, in_sel, in_valid, flush, out_ready,
    output in_ready, out_data, out_sel_err, out_valid, xfer_cnt
  );

  modport master (
    output in_data, in_sel, in_valid, flush, out_ready,
    input  in_ready, out_data, out_sel_err, out_valid, xfer_cnt
  );
endinterface

// File: rtl/mux_pipe_stage.sv
// Registered N-way select with a 2-entry (main + skid) output buffer, flush and
// a free-running output transfer counter.
//
//   state   | meaning
//   --------+---------------------------------------------
//   S_EMPTY | no beat held; out_valid low
//   S_ONE   | main holds a beat; skid empty
//   S_FULL  | main and skid both hold beats; in_ready low
module mux_pipe_stage #(
  parameter int WIDTH  = 64,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = 2,
  parameter int CNT_W  = 16
) (
  input logic               clk,
  input logic               rst_n,
  mux_pipe_stage_if.slave   bus
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [WIDTH-1:0]  r_main_data;
  logic              r_main_err;
  logic [WIDTH-1:0]  r_skid_data;
  logic              r_skid_err;
  logic [CNT_W-1:0]  r_cnt;

  logic [WIDTH-1:0]  w_sel_data;
  logic              w_sel_err;
  logic              w_accept;
  logic              w_xfer;
  logic              w_load_in;
  logic              w_load_skid;
  logic              w_skid_to_main;

  // Out-of-range selects yield zero data with the error flag set.
  always_comb begin
    w_sel_data = '0;
    w_sel_err  = 1'b1;
    for (int k = 0; k < NUM_IN; k++) begin
      if (bus.in_sel == SEL_W'(k)) begin
        w_sel_data = bus.in_data[k*WIDTH +: WIDTH];
        w_sel_err  = 1'b0;
      end
    end
  end

  assign bus.in_ready    = rst_n & (r_state != S_FULL);
  assign bus.out_valid   = (r_state != S_EMPTY);
  assign bus.out_data    = r_main_data;
  assign bus.out_sel_err = r_main_err;
  assign bus.xfer_cnt    = r_cnt;

  assign w_accept = bus.in_valid & bus.in_ready;
  assign w_xfer   = bus.out_valid & bus.out_ready;

  always_comb begin
    w_state_nxt    = r_state;
    w_load_in      = 1'b0;
    w_load_skid    = 1'b0;
    w_skid_to_main = 1'b0;
    if (bus.flush) begin
      w_state_nxt = S_EMPTY;
    end else begin
      case (r_state)
        S_EMPTY: begin
          if (w_accept) begin
            w_state_nxt = S_ONE;
            w_load_in   = 1'b1;
          end
        end
        S_ONE: begin
          if (w_accept && w_xfer) begin
            w_load_in = 1'b1;
          end else if (w_accept) begin
            w_state_nxt = S_FULL;
            w_load_skid = 1'b1;
          end else if (w_xfer) begin
            w_state_nxt = S_EMPTY;
          end
        end
        S_FULL: begin
          if (w_xfer) begin
            w_state_nxt    = S_ONE;
            w_skid_to_main = 1'b1;
          end
        end
        default: w_state_nxt = S_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Main register keeps its contents across a flush; only validity is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_main_data <= '0;
      r_main_err  <= 1'b0;
    end else if (w_load_in) begin
      r_main_data <= w_sel_data;
      r_main_err  <= w_sel_err;
    end else if (w_skid_to_main) begin
      r_main_data <= r_skid_data;
      r_main_err  <= r_skid_err;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_skid_data <= '0;
      r_skid_err  <= 1'b0;
    end else if (bus.flush) begin
      r_skid_data <= '0;
      r_skid_err  <= 1'b0;
    end else if (w_load_skid) begin
      r_skid_data <= w_sel_data;
      r_skid_err  <= w_sel_err;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_xfer) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule
